// File: rtl/rice_bus_sram_slave.sv
// rtl/rice_bus_sram_slave.sv - single-port byte-strobed SRAM slave with in-order read response FIFO
module rice_bus_sram_slave #(
    parameter int                         ADDRESS_WIDTH  = 64,
    parameter int                         DATA_WIDTH     = 64,
    parameter int                         DEPTH          = 1024,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDRESS   = '0,
    parameter int                         RESPONSE_DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    output logic                       o_request_ready,
    input  logic                       i_request_valid,
    input  logic [ADDRESS_WIDTH-1:0]   i_address,
    input  logic [DATA_WIDTH/8-1:0]    i_strobe,
    input  logic [DATA_WIDTH-1:0]      i_write_data,
    input  logic                       i_response_ready,
    output logic                       o_response_valid,
    output logic [DATA_WIDTH-1:0]      o_read_data
);

    localparam int STROBE_WIDTH = DATA_WIDTH / 8;
    localparam int OFFSET_BITS  = $clog2(STROBE_WIDTH);
    localparam int INDEX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_WIDTH    = (RESPONSE_DEPTH > 1) ? $clog2(RESPONSE_DEPTH) : 1;
    localparam int COUNT_WIDTH  = $clog2(RESPONSE_DEPTH + 1);

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_q [RESPONSE_DEPTH];

    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic [PTR_WIDTH-1:0]     wptr_q, wptr_d;
    logic [PTR_WIDTH-1:0]     rptr_q, rptr_d;
    logic                     rst_done_q, rst_done_d;

    logic [ADDRESS_WIDTH-1:0] offset;
    logic [ADDRESS_WIDTH-1:0] word_index;
    logic [INDEX_WIDTH-1:0]   mem_index;
    logic                     in_range;
    logic [DATA_WIDTH-1:0]    read_word;
    logic                     accept;
    logic                     is_write;
    logic                     push;
    logic                     pop;

    function automatic logic [PTR_WIDTH-1:0] ptr_next(input logic [PTR_WIDTH-1:0] p);
        if (p == PTR_WIDTH'(RESPONSE_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Addresses below the base wrap to huge offsets, so the explicit >= keeps them out of range
    always_comb begin
        offset     = i_address - BASE_ADDRESS;
        word_index = offset >> OFFSET_BITS;
        in_range   = (i_address >= BASE_ADDRESS) && (word_index < ADDRESS_WIDTH'(DEPTH));
        mem_index  = word_index[INDEX_WIDTH-1:0];
        read_word  = in_range ? mem[mem_index] : '0;
    end

    assign o_request_ready  = rst_done_q && (count_q < COUNT_WIDTH'(RESPONSE_DEPTH));
    assign o_response_valid = (count_q != '0);
    assign o_read_data      = fifo_q[rptr_q];

    assign accept   = i_request_valid & o_request_ready;
    assign is_write = |i_strobe;
    assign push     = accept & ~is_write;
    assign pop      = o_response_valid & i_response_ready;

    always_comb begin
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rst_done_d = 1'b1;
        if (push) begin
            wptr_d = ptr_next(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_next(rptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + COUNT_WIDTH'(1);
            2'b01:   count_d = count_q - COUNT_WIDTH'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            rst_done_q <= 1'b0;
            for (int i = 0; i < RESPONSE_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rst_done_q <= rst_done_d;
            if (push) begin
                fifo_q[wptr_q] <= read_word;
            end
        end
    end

    // Memory is deliberately not reset so its contents survive a bus reset
    always_ff @(posedge i_clk) begin
        if (accept && is_write && in_range) begin
            for (int k = 0; k < STROBE_WIDTH; k++) begin
                if (i_strobe[k]) begin
                    mem[mem_index][8*k +: 8] <= i_write_data[8*k +: 8];
                end
            end
        end
    end

endmodule
